regfile_wb_sched: RTL and testbench

Write-port scheduler and scoreboard for the 32×32 integer register file. It owns the file's single write port and arbitrates between the single-cycle ALU writeback path and the long-latency unit (loads, mul/div) return path. It tracks registers with pending long-latency writes and generates the issue stall for RAW/WAW hazards and for the outstanding-operation limit. It sits between the decode/issue stage, the execute pipeline and the register file.

---
 rtl/regfile_wb_sched.sv | 143 ++++++++++++++
 tb/tb_regfile_wb_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_sched
// Description : Register-file write-port arbiter (ALU over long unit) and
//               pending-write scoreboard generating the issue stall.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_sched #(
    parameter int MAX_OUT    = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_use_rs1,
    input  logic        issue_use_rs2,
    input  logic        issue_wen,
    input  logic        issue_long,
    output logic        issue_stall,
    input  logic        alu_wb_valid,
    input  logic [4:0]  alu_wb_rd,
    input  logic [31:0] alu_wb_data,
    input  logic        lu_wb_valid,
    input  logic [4:0]  lu_wb_rd,
    input  logic [31:0] lu_wb_data,
    output logic        lu_wb_ready,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wb,
    output logic        rf_wb_sig,
    output logic        err
);

    localparam int c_CNT_W = $clog2(MAX_OUT + 1);
    localparam int c_STV_W = $clog2(STARVE_LIM + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_OUT    = c_CNT_W'(MAX_OUT);
    localparam logic [c_STV_W-1:0] c_STARVE_LIM = c_STV_W'(STARVE_LIM);

    logic [31:0]        r_busy;
    logic [c_CNT_W-1:0] r_out_cnt;
    logic [c_STV_W-1:0] r_starve_cnt;
    logic               r_starve_blk;
    logic               r_err;

    logic [31:0]        w_busy_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_STV_W-1:0] w_starve_nxt;
    logic               w_blk_nxt;
    logic               w_issue_acc;
    logic               w_cnt_inc;
    logic               w_lu_acc;
    logic               w_err_evt;

    // Stall is a function of registered scoreboard state only, so a release
    // on this edge is visible to dependents on the following cycle.
    assign issue_stall = issue_valid &&
                         ((issue_use_rs1 && r_busy[issue_rs1]) ||
                          (issue_use_rs2 && r_busy[issue_rs2]) ||
                          (issue_wen     && r_busy[issue_rd])  ||
                          (issue_long    && (r_out_cnt == c_MAX_OUT)) ||
                          r_starve_blk);

    assign lu_wb_ready = !alu_wb_valid;
    assign w_lu_acc    = lu_wb_valid && lu_wb_ready;
    assign w_issue_acc = issue_valid && !issue_stall;
    assign w_cnt_inc   = w_issue_acc && issue_long;
    assign err         = r_err;

    always_comb begin
        rf_rd     = 5'd0;
        rf_wb     = 32'd0;
        rf_wb_sig = 1'b0;
        if (alu_wb_valid) begin
            rf_rd     = alu_wb_rd;
            rf_wb     = alu_wb_data;
            rf_wb_sig = (alu_wb_rd != 5'd0);
        end else if (lu_wb_valid) begin
            rf_rd     = lu_wb_rd;
            rf_wb     = lu_wb_data;
            rf_wb_sig = (lu_wb_rd != 5'd0);
        end
    end

    // Set before clear so that a forced same-rd set/clear resolves to clear.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_cnt_inc && issue_wen) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        if (w_lu_acc) begin
            w_busy_nxt[lu_wb_rd] = 1'b0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = r_out_cnt;
        if (w_cnt_inc && !w_lu_acc && (r_out_cnt != c_MAX_OUT)) begin
            w_cnt_nxt = r_out_cnt + c_CNT_W'(1);
        end else if (!w_cnt_inc && w_lu_acc && (r_out_cnt != '0)) begin
            w_cnt_nxt = r_out_cnt - c_CNT_W'(1);
        end
    end

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_lu_acc || !lu_wb_valid) begin
            w_starve_nxt = '0;
        end else if (r_starve_cnt != c_STARVE_LIM) begin
            w_starve_nxt = r_starve_cnt + c_STV_W'(1);
        end
        w_blk_nxt = r_starve_blk;
        if (w_lu_acc) begin
            w_blk_nxt = 1'b0;
        end else if (w_starve_nxt == c_STARVE_LIM) begin
            w_blk_nxt = 1'b1;
        end
    end

    assign w_err_evt = (alu_wb_valid && (alu_wb_rd != 5'd0) && r_busy[alu_wb_rd]) ||
                       (w_lu_acc && (r_out_cnt == '0)) ||
                       (w_lu_acc && (lu_wb_rd != 5'd0) && !r_busy[lu_wb_rd]);

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            r_busy       <= '0;
            r_out_cnt    <= '0;
            r_starve_cnt <= '0;
            r_starve_blk <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_out_cnt    <= w_cnt_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_starve_blk <= w_blk_nxt;
            r_err        <= r_err || w_err_evt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_sched
// Description : Directed self-checking bench for regfile_wb_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_sched;

    logic        cpu_clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_use_rs1, issue_use_rs2, issue_wen, issue_long;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_stall;
    logic        alu_wb_valid, lu_wb_valid, lu_wb_ready;
    logic [4:0]  alu_wb_rd, lu_wb_rd, rf_rd;
    logic [31:0] alu_wb_data, lu_wb_data, rf_wb;
    logic        rf_wb_sig, err;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_wb_sched #(.MAX_OUT(4), .STARVE_LIM(8)) dut (
        .cpu_clk(cpu_clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_wen(issue_wen), .issue_long(issue_long), .issue_stall(issue_stall),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .lu_wb_valid(lu_wb_valid), .lu_wb_rd(lu_wb_rd), .lu_wb_data(lu_wb_data),
        .lu_wb_ready(lu_wb_ready), .rf_rd(rf_rd), .rf_wb(rf_wb), .rf_wb_sig(rf_wb_sig),
        .err(err)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change #1 after it, checks follow #1 later.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_issue();
        issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0;
        issue_wen = 0; issue_long = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    endtask

    task automatic issue(input logic lng, input logic wen, input logic [4:0] rd,
                         input logic u1, input logic [4:0] rs1,
                         input logic u2, input logic [4:0] rs2);
        issue_valid = 1; issue_long = lng; issue_wen = wen; issue_rd = rd;
        issue_use_rs1 = u1; issue_rs1 = rs1; issue_use_rs2 = u2; issue_rs2 = rs2;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_wb_valid = v; alu_wb_rd = rd; alu_wb_data = d;
    endtask

    task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lu_wb_valid = v; lu_wb_rd = rd; lu_wb_data = d;
    endtask

    initial begin
        rst = 1; clr_issue(); alu(0, 0, 0); lu(0, 0, 0);
        tick(); tick();
        rst = 0;
        tick();
        settle();
        check("rst_stall", issue_stall, 0);
        check("rst_ready", lu_wb_ready, 1);
        check("rst_sig",   rf_wb_sig, 0);
        check("rst_err",   err, 0);
        check("rst_rf_rd", rf_rd, 0);

        // Long load to x5, then dependent read of x5
        issue(1, 1, 5'd5, 0, 0, 0, 0); settle();
        check("ld5_stall", issue_stall, 0);
        tick();
        issue(0, 0, 0, 1, 5'd5, 0, 0); settle();
        check("raw5_stall", issue_stall, 1);
        tick();
        lu(1, 5'd5, 32'hDEADBEEF); settle();
        check("raw5_stall_ret", issue_stall, 1);
        check("lu5_sig",  rf_wb_sig, 1);
        check("lu5_rd",   rf_rd, 5);
        check("lu5_data", rf_wb, 32'hDEADBEEF);
        tick();
        lu(0, 0, 0); settle();
        check("raw5_release", issue_stall, 0);
        tick();
        clr_issue();

        // ALU priority over long-unit return
        issue(1, 1, 5'd7, 0, 0, 0, 0); tick(); clr_issue();
        alu(1, 5'd3, 32'h33); lu(1, 5'd7, 32'h77); settle();
        check("pri_rd",    rf_rd, 3);
        check("pri_data",  rf_wb, 32'h33);
        check("pri_ready", lu_wb_ready, 0);
        tick();
        alu(0, 0, 0); settle();
        check("lu7_rd",    rf_rd, 7);
        check("lu7_data",  rf_wb, 32'h77);
        check("lu7_ready", lu_wb_ready, 1);
        tick();
        lu(0, 0, 0); settle();
        check("pri_err", err, 0);

        // Outstanding limit
        for (int i = 0; i < 4; i++) begin
            issue(1, 1, 5'(10 + i), 0, 0, 0, 0); tick();
        end
        issue(1, 1, 5'd14, 0, 0, 0, 0); settle();
        check("lim_stall", issue_stall, 1);
        issue(0, 1, 5'd4, 1, 5'd1, 1, 5'd2); settle();
        check("lim_nonlong", issue_stall, 0);
        tick();
        issue(1, 1, 5'd14, 0, 0, 0, 0); lu(1, 5'd10, 32'hA); settle();
        check("lim_stall_ret", issue_stall, 1);
        tick();
        lu(0, 0, 0); settle();
        check("lim_accept", issue_stall, 0);
        tick();
        settle();
        check("lim_full_again", issue_stall, 1);
        clr_issue();

        // Starvation: busy = 11..14, out_cnt = 4
        alu(1, 5'd2, 32'h2); lu(1, 5'd11, 32'hB);
        for (int i = 0; i < 7; i++) tick();
        issue(0, 0, 0, 0, 0, 0, 0); settle();
        check("stv_pre", issue_stall, 0);
        tick();
        check("stv_blk",   issue_stall, 1);
        check("stv_ready", lu_wb_ready, 0);
        alu(0, 0, 0); settle();
        check("stv_accept_ready", lu_wb_ready, 1);
        check("stv_accept_rd",    rf_rd, 11);
        check("stv_blk_hold",     issue_stall, 1);
        tick();
        lu(0, 0, 0); settle();
        check("stv_clear", issue_stall, 0);
        clr_issue();

        // x0 handling: out_cnt 3 -> 4 via long rd=0
        issue(1, 1, 5'd0, 0, 0, 0, 0); settle();
        check("x0_long_stall", issue_stall, 0);
        tick();
        issue(1, 1, 5'd20, 0, 0, 0, 0); settle();
        check("x0_cnt_full", issue_stall, 1);
        issue(0, 0, 0, 1, 5'd0, 0, 0); settle();
        check("x0_not_busy", issue_stall, 0);
        clr_issue();
        alu(1, 5'd0, 32'h55); settle();
        check("alu_x0_sig", rf_wb_sig, 0);
        tick();
        alu(0, 0, 0); lu(1, 5'd0, 32'h66); settle();
        check("lu_x0_sig",   rf_wb_sig, 0);
        check("lu_x0_ready", lu_wb_ready, 1);
        tick();
        lu(0, 0, 0); settle();
        check("x0_err", err, 0);

        // Error paths: busy = 12..14
        alu(1, 5'd12, 32'h9); settle();
        check("err_pre", err, 0);
        tick();
        alu(0, 0, 0); settle();
        check("err_set", err, 1);
        tick();
        check("err_sticky", err, 1);
        rst = 1; tick(); rst = 0; settle();
        check("err_rst", err, 0);
        issue(0, 0, 0, 1, 5'd13, 0, 0); settle();
        check("rst_busy_clr", issue_stall, 0);
        clr_issue();
        lu(1, 5'd13, 32'h13); settle();
        check("post_rst_sig", rf_wb_sig, 1);
        tick();
        lu(0, 0, 0); settle();
        check("post_rst_err", err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
